uart_tx_mux: RTL

Round-robin message arbiter that shares one `uart_tx` write port among `N_CH` independent byte-stream producers. Each producer presents a message: a sequence of bytes whose final byte is flagged `last`. The block locks onto one channel for a whole message so that output lines never interleave. It can optionally prefix each message with an ASCII channel tag ("3:"). It sits directly upstream of `uart_tx` (MODE 0/1, BYTE_WIDTH 1) and drives that block's `wreq`/`wdata` while consuming its `wgnt`.

---
 rtl/uart_tx_mux.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_tx_mux.sv
// Round-robin message arbiter feeding a single uart_tx write port.
// Locks onto one producer for a whole message and can prefix it with an ASCII "<ch>:" tag.
module uart_tx_mux #(
  parameter int N_CH      = 4,
  parameter int PREFIX_EN = 1,
  parameter int TIMEOUT   = 1024,
  localparam int SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   ch_req,
  input  logic [N_CH-1:0]   ch_last,
  input  logic [8*N_CH-1:0] ch_data,
  output logic [N_CH-1:0]   ch_gnt,
  output logic              o_wreq,
  output logic [7:0]        o_wdata,
  input  logic              i_wgnt,
  output logic              o_busy,
  output logic [SEL_W-1:0]  o_sel,
  output logic [1:0]        o_state
);

  // Handshake: a byte moves on any cycle where o_wreq and i_wgnt are both high;
  // o_wreq never looks at i_wgnt, so the sink may derive i_wgnt from o_wreq.

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_M1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TAG   = 2'd1,
    S_COLON = 2'd2,
    S_DATA  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_win_q, last_win_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;

  logic [7:0]         data_arr [N_CH];
  logic [SEL_W-1:0]   pick;
  logic [SEL_W-1:0]   idx_sel;
  logic               found;
  int                 idx;

  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign data_arr[g] = ch_data[8*g +: 8];
  end

  // Rotating search starting just after the last message winner.
  always_comb begin
    pick    = last_win_q;
    found   = 1'b0;
    idx     = 0;
    idx_sel = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx     = (int'(last_win_q) + i) % N_CH;
      idx_sel = SEL_W'(idx);
      if (!found && ch_req[idx_sel]) begin
        found = 1'b1;
        pick  = idx_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      last_win_q <= SEL_W'(N_CH - 1);
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_win_q <= last_win_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_win_d = last_win_q;
    idle_cnt_d = idle_cnt_q;
    o_wreq     = 1'b0;
    o_wdata    = '0;
    ch_gnt     = '0;
    unique case (state_q)
      S_IDLE: begin
        idle_cnt_d = '0;
        if (found) begin
          sel_d   = pick;
          state_d = (PREFIX_EN != 0) ? S_TAG : S_DATA;
        end
      end
      S_TAG: begin
        idle_cnt_d = '0;
        o_wreq     = 1'b1;
        o_wdata    = 8'h30 + 8'(sel_q);
        if (i_wgnt) state_d = S_COLON;
      end
      S_COLON: begin
        idle_cnt_d = '0;
        o_wreq     = 1'b1;
        o_wdata    = 8'h3A;
        if (i_wgnt) state_d = S_DATA;
      end
      S_DATA: begin
        o_wreq        = ch_req[sel_q];
        o_wdata       = data_arr[sel_q];
        ch_gnt[sel_q] = ch_req[sel_q] & i_wgnt;
        if (ch_req[sel_q]) begin
          idle_cnt_d = '0;
          if (i_wgnt && ch_last[sel_q]) begin
            state_d    = S_IDLE;
            last_win_d = sel_q;
          end
        end else if (TIMEOUT > 0) begin
          // A stalled producer gives up the lock; its message is simply cut short.
          if (idle_cnt_q == CNT_W'(TO_M1)) begin
            state_d    = S_IDLE;
            last_win_d = sel_q;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy  = (state_q != S_IDLE);
  assign o_sel   = sel_q;
  assign o_state = state_q;

endmodule
